projectile_launcher: RTL
========================

// Module: projectile_launcher
// PURPOSE
//  Downstream consumer of the cursor unit-vector stage. On a fire press it latches the signed
//  direction vector, spawns a projectile at screen centre (320,240) and advances it once per frame.
//  Advance is fixed-point position += vector*SPEED. It retires the projectile when it leaves the
//  640x480 screen and enforces a cooldown before the next shot. Outputs feed the colour mapper.
// PARAMETERS
//  SPEED            4   pixels/frame at unit magnitude (1..15); 255 in the vector = 1.0 (Q.8)
//  COOLDOWN_FRAMES  8   frame ticks spent in COOLDOWN after retirement (0..255)
// PORTS
//  Clk         in   1   system clock; single clock domain
//  Reset       in   1   synchronous, active-high reset
//  frame_clk   in   1   vsync-rate level signal; rising edge = one frame tick
//  fire        in   1   fire button level; launch on rising edge only
//  x_vector    in   9   signed 2's-comp x direction, -255..255, +x = right
//  y_vector    in   9   signed 2's-comp y direction, -255..255, +y = UP (screen y decreases)
//  proj_active out  1   projectile on screen; proj_x/proj_y valid when 1
//  proj_x      out  10  integer pixel column, 0..639
//  proj_y      out  10  integer pixel row, 0..479
//  launch      out  1   one-cycle pulse in the cycle the FLIGHT state is entered
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, position/velocity/counters 0, edge-detect regs 0.
//   Reset mid-flight or mid-cooldown aborts immediately; the next cycle is IDLE.
//  Edge detect:
//   - frame_clk and fire are each registered once.
//   - tick = frame_clk & ~frame_clk_q; fire_edge = fire & ~fire_q.
//   - Holding fire never retriggers.
//  States: IDLE, LATCH, FLIGHT, COOLDOWN.
//   IDLE: fire_edge -> LATCH. A tick in IDLE is ignored.
//   LATCH: one cycle, absorbs the 1-cycle LUT latency of the vector stage.
//    - Sample x_vector/y_vector.
//    - Both zero: return to IDLE, no launch.
//    - Otherwise: vel_x = x_vector*SPEED, vel_y = -(y_vector*SPEED) (13-bit signed);
//      pos_x = 320<<8, pos_y = 240<<8; -> FLIGHT; launch=1 for that one cycle.
//   FLIGHT: proj_active=1.
//    - On tick: nx = pos_x+vel_x, ny = pos_y+vel_y.
//    - If nx<0 or nx>=640<<8 or ny<0 or ny>=480<<8: -> COOLDOWN, proj_active=0 next cycle,
//      position not updated.
//    - Else pos <= n.
//   COOLDOWN: 8-bit counter counts ticks. Reaching COOLDOWN_FRAMES -> IDLE; if
//    COOLDOWN_FRAMES=0, -> IDLE on the next cycle.
//  fire_edge outside IDLE is ignored and is not queued.
//  Arithmetic:
//   - Positions are signed Q11.8 (19 bits), so intermediates never overflow.
//   - proj_x = pos_x[17:8], proj_y = pos_y[17:8] (truncation toward zero).
//   - Outputs are registered. proj_x/proj_y hold their last value outside FLIGHT and read 0 after reset.
//  Latency: fire_edge at cycle N -> LATCH N+1 -> launch and proj_active=1 at N+2 with (320,240).
//   Tick in FLIGHT at cycle T -> new position visible at T+1.
// TESTING
//  1 Reset asserted 3 cycles mid-flight -> next cycle proj_active=0, proj_x=proj_y=0, launch=0;
//    fire edge then launches normally.
//  2 x=255,y=0, SPEED=4, fire edge at N -> launch=1 at N+2, (320,240); tick1 -> proj_x=323;
//    tick2 -> 327; proj_y stays 240.
//  3 Same shot -> after tick80 proj_x=638, active; tick81 (nx=642.7) -> proj_active=0, COOLDOWN.
//  4 x=0,y=-255 (cursor below centre) -> tick1 proj_y=243, proj_x=320; x=0,y=255 -> proj_y=236.
//  5 x=y=0 at LATCH -> no launch pulse, proj_active stays 0, state back to IDLE.
//  6 Fire held across launch, re-pressed in FLIGHT and during cooldown -> ignored;
//    a press after the 8th cooldown tick -> launch.

Source files
------------

// File: rtl/projectile_launcher.sv
// Single-projectile launcher: latches a direction on a fire press, flies it from screen
// centre in Q11.8 fixed point once per frame tick, retires it off-screen, then cools down.
module projectile_launcher #(
   parameter int SPEED           = 4,
   parameter int COOLDOWN_FRAMES = 8
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       fire,
   input  logic [8:0] x_vector,
   input  logic [8:0] y_vector,
   output logic       proj_active,
   output logic [9:0] proj_x,
   output logic [9:0] proj_y,
   output logic       launch,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_LATCH    = 2'd1,
      S_FLIGHT   = 2'd2,
      S_COOLDOWN = 2'd3
   } state_t;

   localparam logic signed [12:0] SPEED_S = 13'(SPEED);
   localparam logic        [7:0]  COOL_N  = 8'(COOLDOWN_FRAMES);
   localparam logic signed [18:0] CX_Q8   = 19'(320 * 256);
   localparam logic signed [18:0] CY_Q8   = 19'(240 * 256);
   localparam logic signed [18:0] XMAX_Q8 = 19'(640 * 256);
   localparam logic signed [18:0] YMAX_Q8 = 19'(480 * 256);

   state_t             state_q, state_d;
   logic               frame_clk_q, frame_clk_d;
   logic               fire_q, fire_d;
   logic signed [18:0] pos_x_q, pos_x_d;
   logic signed [18:0] pos_y_q, pos_y_d;
   logic signed [12:0] vel_x_q, vel_x_d;
   logic signed [12:0] vel_y_q, vel_y_d;
   logic        [7:0]  cool_cnt_q, cool_cnt_d;
   logic               active_q, active_d;
   logic               launch_q, launch_d;
   logic        [9:0]  proj_x_q, proj_x_d;
   logic        [9:0]  proj_y_q, proj_y_d;

   logic               tick;
   logic               fire_edge;
   logic signed [12:0] x_ext;
   logic signed [12:0] y_ext;
   logic signed [18:0] nx;
   logic signed [18:0] ny;
   logic               off_screen;

   assign tick      = frame_clk & ~frame_clk_q;
   assign fire_edge = fire & ~fire_q;

   assign x_ext = {{4{x_vector[8]}}, x_vector};
   assign y_ext = {{4{y_vector[8]}}, y_vector};

   assign nx = pos_x_q + {{6{vel_x_q[12]}}, vel_x_q};
   assign ny = pos_y_q + {{6{vel_y_q[12]}}, vel_y_q};

   // Screen y grows downward while the vector's +y means up, hence the negated vel_y.
   assign off_screen = (nx < 19'sd0) || (nx >= XMAX_Q8) ||
                       (ny < 19'sd0) || (ny >= YMAX_Q8);

   always_comb begin
      state_d     = state_q;
      frame_clk_d = frame_clk;
      fire_d      = fire;
      pos_x_d     = pos_x_q;
      pos_y_d     = pos_y_q;
      vel_x_d     = vel_x_q;
      vel_y_d     = vel_y_q;
      cool_cnt_d  = cool_cnt_q;
      active_d    = active_q;
      launch_d    = 1'b0;
      proj_x_d    = proj_x_q;
      proj_y_d    = proj_y_q;

      case (state_q)
         S_IDLE: begin
            if (fire_edge) state_d = S_LATCH;
         end

         S_LATCH: begin
            if ((x_vector == 9'd0) && (y_vector == 9'd0)) begin
               state_d = S_IDLE;
            end else begin
               vel_x_d  = x_ext * SPEED_S;
               vel_y_d  = -(y_ext * SPEED_S);
               pos_x_d  = CX_Q8;
               pos_y_d  = CY_Q8;
               active_d = 1'b1;
               launch_d = 1'b1;
               proj_x_d = 10'd320;
               proj_y_d = 10'd240;
               state_d  = S_FLIGHT;
            end
         end

         S_FLIGHT: begin
            if (tick) begin
               if (off_screen) begin
                  active_d   = 1'b0;
                  cool_cnt_d = 8'd0;
                  state_d    = S_COOLDOWN;
               end else begin
                  pos_x_d  = nx;
                  pos_y_d  = ny;
                  proj_x_d = nx[17:8];
                  proj_y_d = ny[17:8];
               end
            end
         end

         S_COOLDOWN: begin
            if (COOL_N == 8'd0) begin
               state_d = S_IDLE;
            end else if (tick) begin
               if (cool_cnt_q == COOL_N - 8'd1) begin
                  cool_cnt_d = 8'd0;
                  state_d    = S_IDLE;
               end else begin
                  cool_cnt_d = cool_cnt_q + 8'd1;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         frame_clk_q <= 1'b0;
         fire_q      <= 1'b0;
         pos_x_q     <= '0;
         pos_y_q     <= '0;
         vel_x_q     <= '0;
         vel_y_q     <= '0;
         cool_cnt_q  <= '0;
         active_q    <= 1'b0;
         launch_q    <= 1'b0;
         proj_x_q    <= '0;
         proj_y_q    <= '0;
      end else begin
         state_q     <= state_d;
         frame_clk_q <= frame_clk_d;
         fire_q      <= fire_d;
         pos_x_q     <= pos_x_d;
         pos_y_q     <= pos_y_d;
         vel_x_q     <= vel_x_d;
         vel_y_q     <= vel_y_d;
         cool_cnt_q  <= cool_cnt_d;
         active_q    <= active_d;
         launch_q    <= launch_d;
         proj_x_q    <= proj_x_d;
         proj_y_q    <= proj_y_d;
      end
   end

   assign proj_active = active_q;
   assign launch      = launch_q;
   assign proj_x      = proj_x_q;
   assign proj_y      = proj_y_q;
   assign state_dbg   = state_q;

endmodule
